// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: owns the PC, issues one imem request at a time,
// buffers the fetched word for decode, and applies branch redirects and halt.
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] HALT_INSTR = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  input  logic        redirect_en,
  input  logic [31:0] redirect_pc,
  input  logic [15:0] redirect_offset,
  output logic        halted,
  output logic [31:0] fetch_count
);

  localparam int unsigned XLEN     = 32;
  localparam int unsigned OFF_W    = 16;
  localparam int unsigned PC_STEP  = 4;

  typedef enum logic [1:0] {
    ST_FETCH  = 2'd0,
    ST_WAIT   = 2'd1,
    ST_FULL   = 2'd2,
    ST_HALTED = 2'd3
  } state_t;

  state_t            state, state_n;
  logic [XLEN-1:0]   pc, pc_n;
  logic              drop, drop_n;
  logic              if_valid_n;
  logic [XLEN-1:0]   if_instr_n;
  logic [XLEN-1:0]   if_pc_n;
  logic              halted_n;
  logic [XLEN-1:0]   fetch_count_n;
  logic [XLEN-1:0]   offset_ext;
  logic [XLEN-1:0]   redirect_sum;
  logic [XLEN-1:0]   redirect_target;

  // Branch target: sign-extended offset added to base, word aligned.
  always_comb begin
    offset_ext      = {{(XLEN-OFF_W){redirect_offset[OFF_W-1]}}, redirect_offset};
    redirect_sum    = redirect_pc + offset_ext;
    redirect_target = redirect_sum & ~XLEN'(3);
  end

  // Request is decoded from state so it can be accepted in the issue cycle.
  always_comb begin
    imem_req  = (state == ST_FETCH) && !reset;
    imem_addr = pc;
  end

  // Next-state and next-register logic; redirect overrides normal sequencing.
  always_comb begin
    state_n       = state;
    pc_n          = pc;
    drop_n        = drop;
    if_valid_n    = if_valid;
    if_instr_n    = if_instr;
    if_pc_n       = if_pc;
    halted_n      = halted;
    fetch_count_n = fetch_count;

    if (redirect_en) begin
      pc_n       = redirect_target;
      if_valid_n = 1'b0;
      halted_n   = 1'b0;
      case (state)
        ST_FETCH: begin
          // Old address accepted this cycle: its response must be discarded.
          if (imem_gnt) begin
            state_n = ST_WAIT;
            drop_n  = 1'b1;
          end
        end
        ST_WAIT: begin
          if (imem_rvalid) begin
            state_n = ST_FETCH;
            drop_n  = 1'b0;
          end else begin
            drop_n  = 1'b1;
          end
        end
        default: state_n = ST_FETCH;
      endcase
    end else begin
      case (state)
        ST_FETCH: begin
          if (imem_gnt) state_n = ST_WAIT;
        end
        ST_WAIT: begin
          if (imem_rvalid) begin
            if (drop) begin
              drop_n  = 1'b0;
              state_n = ST_FETCH;
            end else begin
              if_instr_n = imem_rdata;
              if_pc_n    = pc;
              pc_n       = pc + XLEN'(PC_STEP);
              if_valid_n = 1'b1;
              state_n    = ST_FULL;
            end
          end
        end
        ST_FULL: begin
          if (if_ready) begin
            fetch_count_n = fetch_count + XLEN'(1);
            if_valid_n    = 1'b0;
            if (if_instr == HALT_INSTR) begin
              state_n  = ST_HALTED;
              halted_n = 1'b1;
            end else begin
              state_n  = ST_FETCH;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_FETCH;
      pc          <= RESET_PC;
      drop        <= 1'b0;
      if_valid    <= 1'b0;
      if_instr    <= '0;
      if_pc       <= '0;
      halted      <= 1'b0;
      fetch_count <= '0;
    end else begin
      state       <= state_n;
      pc          <= pc_n;
      drop        <= drop_n;
      if_valid    <= if_valid_n;
      if_instr    <= if_instr_n;
      if_pc       <= if_pc_n;
      halted      <= halted_n;
      fetch_count <= fetch_count_n;
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: zero-wait memory model feeding a
// scoreboard of {pc, word}, checked whenever decode consumes an instruction.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        if_valid;
  logic        if_ready = 1'b0;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        redirect_en = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic [15:0] redirect_offset = '0;
  logic        halted;
  logic [31:0] fetch_count;

  fetch_sequencer dut (
    .clk             (clk),
    .reset           (reset),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_gnt        (imem_gnt),
    .imem_rvalid     (imem_rvalid),
    .imem_rdata      (imem_rdata),
    .if_valid        (if_valid),
    .if_ready        (if_ready),
    .if_instr        (if_instr),
    .if_pc           (if_pc),
    .redirect_en     (redirect_en),
    .redirect_pc     (redirect_pc),
    .redirect_offset (redirect_offset),
    .halted          (halted),
    .fetch_count     (fetch_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Single comparison point for the whole bench.
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [63:0] exp_q[$];
  int          cons_times[$];
  int          cons_n = 0;
  int          exp_count = 0;
  logic [31:0] last_cons_pc = '0;
  bit          halt_cons = 1'b0;
  logic [31:0] halt_addr = 32'h0000_0001;
  bit          hold_rvalid = 1'b0;
  bit          mem_pend = 1'b0;
  logic [31:0] mem_paddr = '0;
  logic [63:0] mon_e;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a == halt_addr) ? 32'hFFFF_FFFF : (a ^ 32'hA5A5_0000);
  endfunction

  // Memory: grant in request cycle, respond one cycle later; shares reset.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      imem_gnt    = 1'b0;
      imem_rvalid = 1'b0;
      if (reset) begin
        mem_pend = 1'b0;
      end else if (mem_pend && !hold_rvalid) begin
        imem_rvalid = 1'b1;
        imem_rdata  = mem_word(mem_paddr);
        mem_pend    = 1'b0;
      end else if (imem_req && !mem_pend) begin
        imem_gnt  = 1'b1;
        mem_pend  = 1'b1;
        mem_paddr = imem_addr;
        exp_q.push_back({imem_addr, mem_word(imem_addr)});
      end
    end
  end

  // Consume monitor: every delivered instruction must match the scoreboard head.
  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        exp_count = 0;
      end else if (if_valid && if_ready && !redirect_en) begin
        check("fetch_count_at_consume", fetch_count, 32'(exp_count));
        check("scoreboard_depth", 32'(exp_q.size()), 32'd1);
        if (exp_q.size() > 0) begin
          mon_e = exp_q.pop_front();
          check("if_pc", if_pc, mon_e[63:32]);
          check("if_instr", if_instr, mon_e[31:0]);
          if (mon_e[31:0] == 32'hFFFF_FFFF) halt_cons = 1'b1;
        end
        exp_count++;
        cons_n++;
        last_cons_pc = if_pc;
        cons_times.push_back(cyc);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #3;
  endtask

  task automatic do_redirect(input logic [31:0] base, input logic [15:0] off);
    redirect_en     = 1'b1;
    redirect_pc     = base;
    redirect_offset = off;
    exp_q.delete();
    tick();
    redirect_en = 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (!if_valid && n < 50) begin tick(); n++; end
    check(tag, 32'(if_valid), 32'd1);
  endtask

  task automatic wait_req(input string tag);
    int n = 0;
    while (!imem_req && n < 50) begin tick(); n++; end
    check(tag, 32'(imem_req), 32'd1);
  endtask

  task automatic wait_wait_state(input string tag);
    int n = 0;
    while (!(mem_pend && !imem_req) && n < 50) begin tick(); n++; end
    check(tag, 32'(mem_pend && !imem_req), 32'd1);
  endtask

  task automatic wait_cons(input string tag, input int target);
    int n = 0;
    while (cons_n < target && n < 100) begin tick(); n++; end
    check(tag, 32'(cons_n), 32'(target));
  endtask

  task automatic wait_gnt_at(input string tag, input logic [31:0] addr);
    int n = 0;
    while (!(imem_gnt && imem_addr == addr) && n < 50) begin tick(); n++; end
    check(tag, imem_addr, addr);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;

    // Reset values.
    tick();
    tick();
    check("rst_req", 32'(imem_req), 32'd0);
    check("rst_valid", 32'(if_valid), 32'd0);
    check("rst_instr", if_instr, 32'd0);
    check("rst_pc", if_pc, 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_count", fetch_count, 32'd0);
    if_ready = 1'b1;
    reset    = 1'b0;
    tick();
    check("first_req", 32'(imem_req), 32'd1);
    check("first_addr", imem_addr, 32'h0);

    // Streaming at full rate with decode always ready.
    wait_cons("t1_cons", 4);
    if_ready = 1'b0;
    check("t1_count", fetch_count, 32'd4);
    check("t1_last_pc", last_cons_pc, 32'hC);
    if (cons_times.size() >= 4) begin
      for (int i = 1; i < 4; i++)
        check("t1_cadence", 32'(cons_times[i] - cons_times[i-1]), 32'd3);
    end

    // Decode back-pressure holds the buffer and blocks new requests.
    wait_valid("t2_valid");
    check("t2_pc", if_pc, 32'h10);
    repeat (5) begin
      check("t2_hold_valid", 32'(if_valid), 32'd1);
      check("t2_hold_instr", if_instr, 32'h10 ^ 32'hA5A5_0000);
      check("t2_no_req", 32'(imem_req), 32'd0);
      tick();
    end
    if_ready = 1'b1;
    tick();
    check("t2_next_req", 32'(imem_req), 32'd1);
    check("t2_next_addr", imem_addr, 32'h14);

    // Redirect while waiting for a response: in-flight word is dropped.
    hold_rvalid = 1'b1;
    wait_wait_state("t3_in_wait");
    do_redirect(32'h100, 16'hFFF0);
    hold_rvalid = 1'b0;
    check("t3_no_valid_a", 32'(if_valid), 32'd0);
    tick();
    check("t3_no_valid_b", 32'(if_valid), 32'd0);
    tick();
    check("t3_no_valid_c", 32'(if_valid), 32'd0);
    wait_req("t3_req");
    check("t3_addr", imem_addr, 32'hF0);
    base = cons_n;
    wait_cons("t3_cons", base + 1);
    check("t3_first_pc", last_cons_pc, 32'hF0);

    // Redirect from FULL, then redirect coinciding with a grant.
    if_ready = 1'b0;
    wait_valid("t4_valid");
    do_redirect(32'h10, 16'h0010);
    check("t4_flush", 32'(if_valid), 32'd0);
    if_ready = 1'b1;
    wait_gnt_at("t4_gnt20", 32'h20);
    do_redirect(32'h3FF, 16'h0003);
    wait_req("t4_req");
    check("t4_addr", imem_addr, 32'h400);
    base = cons_n;
    wait_cons("t4_cons", base + 1);
    check("t4_first_pc", last_cons_pc, 32'h400);

    // Halt instruction at 0x8, then resume via redirect.
    if_ready = 1'b0;
    wait_valid("t5_valid");
    halt_addr = 32'h8;
    halt_cons = 1'b0;
    do_redirect(32'h0, 16'h0000);
    if_ready = 1'b1;
    begin
      int n = 0;
      while (!halt_cons && n < 60) begin tick(); n++; end
    end
    check("t5_halt_seen", 32'(halt_cons), 32'd1);
    check("t5_halted", 32'(halted), 32'd1);
    check("t5_halt_pc", last_cons_pc, 32'h8);
    check("t5_count", fetch_count, 32'(exp_count));
    repeat (10) begin
      check("t5_no_req", 32'(imem_req), 32'd0);
      check("t5_no_valid", 32'(if_valid), 32'd0);
      tick();
    end
    check("t5_still_halted", 32'(halted), 32'd1);
    do_redirect(32'h40, 16'h0000);
    halt_addr = 32'h0000_0001;
    check("t5_unhalted", 32'(halted), 32'd0);
    check("t5_resume_req", 32'(imem_req), 32'd1);
    check("t5_resume_addr", imem_addr, 32'h40);
    base = cons_n;
    wait_cons("t5_cons", base + 1);
    check("t5_resume_pc", last_cons_pc, 32'h40);

    // PC wrap at the top of the address space.
    if_ready = 1'b0;
    wait_valid("t6_valid");
    do_redirect(32'hFFFF_FFF0, 16'h000C);
    if_ready = 1'b1;
    base = cons_n;
    wait_cons("t6_cons", base + 1);
    check("t6_top_pc", last_cons_pc, 32'hFFFF_FFFC);
    check("t6_wrap_req", 32'(imem_req), 32'd1);
    check("t6_wrap_addr", imem_addr, 32'h0);

    // Reset while a response is outstanding.
    hold_rvalid = 1'b1;
    wait_wait_state("t6_in_wait");
    reset = 1'b1;
    exp_q.delete();
    tick();
    check("t6_rst_req", 32'(imem_req), 32'd0);
    check("t6_rst_valid", 32'(if_valid), 32'd0);
    check("t6_rst_instr", if_instr, 32'd0);
    check("t6_rst_pc", if_pc, 32'd0);
    check("t6_rst_halted", 32'(halted), 32'd0);
    check("t6_rst_count", fetch_count, 32'd0);
    reset       = 1'b0;
    hold_rvalid = 1'b0;
    tick();
    check("t6_post_req", 32'(imem_req), 32'd1);
    check("t6_post_addr", imem_addr, 32'h0);
    base = cons_n;
    wait_cons("t6_post_cons", base + 1);
    check("t6_post_pc", last_cons_pc, 32'h0);
    check("t6_post_count", fetch_count, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
